register_file: RTL and testbench

- 32-entry integer register file for the single-cycle RISC-V core: two read ports, one write-back port.
- Sits between decode and execute.
  - Decode supplies rs1 and rs2.
  - Write-back supplies rd, writeData and writeEn.
  - read1 and read2 feed the ALU operand registers.
- Holds an explicit clear sequencer, so the array maps onto plain storage with no per-entry reset.

---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_read_port.sv | 33 +++
 rtl/register_file.sv | 96 +++++++++
 tb/tb_register_file.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared sizing, register-index constants and sequencer states for the integer register file.
package rf_pkg;

    localparam int REGS = 32;
    localparam int ADDR = $clog2(REGS);

    localparam logic [ADDR-1:0] ZERO_REG = '0;
    localparam logic [ADDR-1:0] LAST_REG = ADDR'(REGS - 1);

    typedef enum logic {
        CLEAR,
        READY
    } rf_state_t;

endpackage

// File: rtl/rf_read_port.sv
// Read port: selects x0 / write-back bypass / array data into the output register.
// Latency: 1 cycle from index to data.
// Backpressure: none; captures every cycle, held at zero while clearing.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int BITS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [ADDR-1:0]   rs,
    input  logic [ADDR-1:0]   rd,
    input  logic              wr_en,
    input  logic [0:BITS-1]   wr_data,
    input  logic [0:BITS-1]   arr_data,
    output logic [0:BITS-1]   read
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            read <= '0;
        end else if (rs == ZERO_REG) begin
            read <= '0;
        end else if (wr_en && (rs == rd)) begin
            // Forward the value being written this edge, not the stale entry.
            read <= wr_data;
        end else begin
            read <= arr_data;
        end
    end

endmodule

// File: rtl/register_file.sv
// 32-entry register file, two registered read ports, one write port, self-clearing after reset.
// Latency: read data 1 cycle after index; ready rises 31 cycles after reset release.
// Backpressure: none; writes are silently dropped and reads forced to zero until ready.
module register_file
    import rf_pkg::*;
#(
    parameter int BITS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR-1:0]   rs1,
    input  logic [ADDR-1:0]   rs2,
    input  logic [ADDR-1:0]   rd,
    input  logic [0:BITS-1]   writeData,
    input  logic              writeEn,
    output logic [0:BITS-1]   read1,
    output logic [0:BITS-1]   read2,
    output logic              ready
);

    rf_state_t       state_q, state_d;
    logic [ADDR-1:0] clr_idx_q, clr_idx_d;
    logic [0:BITS-1] mem [REGS];
    logic            clearing;
    logic            wr_en;

    assign clearing = (state_q == CLEAR);
    assign wr_en    = writeEn && (rd != ZERO_REG) && (state_q == READY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= ADDR'(1);
            ready     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready     <= (state_d == READY);
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + ADDR'(1);
                if (clr_idx_q == LAST_REG) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Plain storage: no per-entry reset; the sweep zeroes entries 1..REGS-1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clearing) begin
                mem[clr_idx_q] <= '0;
            end else if (wr_en) begin
                mem[rd] <= writeData;
            end
        end
    end

    rf_read_port #(.BITS(BITS)) u_port1 (
        .clk      (clk),
        .rst      (rst),
        .clear    (clearing),
        .rs       (rs1),
        .rd       (rd),
        .wr_en    (wr_en),
        .wr_data  (writeData),
        .arr_data (mem[rs1]),
        .read     (read1)
    );

    rf_read_port #(.BITS(BITS)) u_port2 (
        .clk      (clk),
        .rst      (rst),
        .clear    (clearing),
        .rs       (rs2),
        .rd       (rd),
        .wr_en    (wr_en),
        .wr_data  (writeData),
        .arr_data (mem[rs2]),
        .read     (read2)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: clear sweep timing, read latency, bypass, x0 and resets.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1, rs2, rd;
    logic [0:63] writeData;
    logic        writeEn;
    logic [0:63] read1, read2;
    logic        ready;

    int passes = 0;
    int total  = 0;
    int n;
    bit nonzero;

    always #5 clk = ~clk;

    register_file #(.BITS(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .writeData (writeData),
        .writeEn   (writeEn),
        .read1     (read1),
        .read2     (read2),
        .ready     (ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Counts edges until ready rises (bounded); injects a write on the 10th edge if asked.
    task automatic wait_ready(input bit inject, output int cnt, output bit nz);
        cnt = 0;
        nz  = 1'b0;
        while (!ready && cnt < 200) begin
            if (inject && cnt == 9) begin
                writeEn = 1'b1; rd = 5'd3; writeData = 64'hAA;
            end else begin
                writeEn = 1'b0;
            end
            tick();
            cnt++;
            if (read1 !== 64'd0 || read2 !== 64'd0) nz = 1'b1;
        end
        writeEn = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd0;
        writeData = 64'd0; writeEn = 1'b0;
        tick();
        chk("reset_ready", {63'd0, ready}, 64'd0);
        chk("reset_read1", read1, 64'd0);
        chk("reset_read2", read2, 64'd0);

        rst = 1'b0;
        wait_ready(1'b1, n, nonzero);
        chk("sweep_ready_cycles", 64'(n), 64'd31);
        chk("sweep_reads_zero", {63'd0, nonzero}, 64'd0);

        // Basic write then read with 1-cycle latency
        writeEn = 1'b1; rd = 5'd5; writeData = 64'hDEADBEEF_00000001; rs1 = 5'd0; rs2 = 5'd0;
        tick();
        writeEn = 1'b0; rs1 = 5'd5; rs2 = 5'd7;
        tick();
        chk("basic_read1", read1, 64'hDEADBEEF_00000001);
        chk("unwritten_read2", read2, 64'd0);

        rs1 = 5'd3;
        tick();
        chk("clear_write_dropped", read1, 64'd0);

        // Bypass on both ports
        writeEn = 1'b1; rd = 5'd9; writeData = 64'h1234; rs1 = 5'd9; rs2 = 5'd9;
        tick();
        chk("bypass_read1", read1, 64'h1234);
        chk("bypass_read2", read2, 64'h1234);
        writeEn = 1'b0; rs1 = 5'd9; rs2 = 5'd5;
        tick();
        chk("persist_read1", read1, 64'h1234);
        chk("persist_read2", read2, 64'hDEADBEEF_00000001);

        // Independent bypass: only port 1 matches rd
        writeEn = 1'b1; rd = 5'd5; writeData = 64'h77; rs1 = 5'd5; rs2 = 5'd9;
        tick();
        chk("bypass1_only_read1", read1, 64'h77);
        chk("bypass1_only_read2", read2, 64'h1234);
        writeEn = 1'b0;

        // x0 protection
        writeEn = 1'b1; rd = 5'd0; writeData = '1; rs1 = 5'd0; rs2 = 5'd5;
        tick();
        chk("x0_bypass_read1", read1, 64'd0);
        chk("x0_other_read2", read2, 64'h77);
        writeEn = 1'b0; rs1 = 5'd9; rs2 = 5'd0;
        tick();
        chk("x0_read2", read2, 64'd0);
        chk("x0_no_side_effect_read1", read1, 64'h1234);

        // Reset while READY
        writeEn = 1'b1; rd = 5'd12; writeData = 64'h55; rs1 = 5'd0; rs2 = 5'd0;
        tick();
        writeEn = 1'b0; rs1 = 5'd12;
        tick();
        chk("pre_reset_read1", read1, 64'h55);
        rst = 1'b1;
        tick();
        chk("rst_ready_drop", {63'd0, ready}, 64'd0);
        chk("rst_read1_zero", read1, 64'd0);
        rst = 1'b0;

        // Reset again at sweep cycle 20
        for (int i = 0; i < 20; i++) tick();
        chk("mid_sweep_not_ready", {63'd0, ready}, 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready(1'b0, n, nonzero);
        chk("restart_ready_cycles", 64'(n), 64'd31);
        chk("restart_reads_zero", {63'd0, nonzero}, 64'd0);

        rs1 = 5'd12; rs2 = 5'd5;
        tick();
        chk("reset_lost_read1", read1, 64'd0);
        chk("reset_lost_read2", read2, 64'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
